// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle for dmem_port_arbiter: two requester ports plus the data_memory side.
// master = requesters and memory model, slave = the arbiter.
interface dmem_port_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              gnt0;
  logic              gnt1;
  logic              done0;
  logic              done1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  gnt0, gnt1, done0, done1, rdata0, rdata1,
           mem_read, mem_write, mem_addr, mem_wdata
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output gnt0, gnt1, done0, done1, rdata0, rdata1,
           mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter in front of data_memory with an issue/wait/respond sequencer.
// Define DMEM_FIXED_PRIO_EN for fixed port-0 priority; default is round-robin.
//
// state | meaning
// IDLE  | no access in flight; arbitrate and latch the winner's fields
// ISSUE | gnt pulse and one-cycle MemRead/MemWrite strobe
// WAIT  | memory read latency countdown (skipped when MEM_LATENCY=0)
// RESP  | done pulse; read data already captured into the owner's rdata
module dmem_port_arbiter #(
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 64,
  parameter int MEM_LATENCY = 1
) (
  input logic               clk,
  input logic               reset,
  dmem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [3:0] CNT_LOAD = (MEM_LATENCY > 0) ? 4'(MEM_LATENCY - 1) : 4'd0;

  state_t     state;
  logic       owner;
  logic       we_q;
  logic [3:0] cnt;
  logic       pick1;
  logic       enter_resp;

`ifdef DMEM_FIXED_PRIO_EN
  always_comb begin
    pick1 = bus.req1 & ~bus.req0;
  end
`else
  logic last_owner;

  // on a tie, the port that was not served last wins
  always_comb begin
    pick1 = bus.req1 & (~bus.req0 | ~last_owner);
  end
`endif

  always_comb begin
    enter_resp = ((state == ISSUE) && (MEM_LATENCY == 0)) ||
                 ((state == WAIT) && (cnt == 4'd0));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      owner         <= 1'b0;
      we_q          <= 1'b0;
      cnt           <= 4'd0;
`ifndef DMEM_FIXED_PRIO_EN
      last_owner    <= 1'b1;
`endif
      bus.gnt0      <= 1'b0;
      bus.gnt1      <= 1'b0;
      bus.done0     <= 1'b0;
      bus.done1     <= 1'b0;
      bus.rdata0    <= '0;
      bus.rdata1    <= '0;
      bus.mem_read  <= 1'b0;
      bus.mem_write <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      bus.gnt0      <= 1'b0;
      bus.gnt1      <= 1'b0;
      bus.done0     <= 1'b0;
      bus.done1     <= 1'b0;
      bus.mem_read  <= 1'b0;
      bus.mem_write <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req0 | bus.req1) begin
            owner         <= pick1;
`ifndef DMEM_FIXED_PRIO_EN
            last_owner    <= pick1;
`endif
            we_q          <= pick1 ? bus.we1 : bus.we0;
            bus.mem_addr  <= pick1 ? bus.addr1 : bus.addr0;
            bus.mem_wdata <= pick1 ? bus.wdata1 : bus.wdata0;
            bus.gnt0      <= ~pick1;
            bus.gnt1      <= pick1;
            bus.mem_read  <= ~(pick1 ? bus.we1 : bus.we0);
            bus.mem_write <= pick1 ? bus.we1 : bus.we0;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          if (MEM_LATENCY == 0) begin
            state <= RESP;
          end else begin
            cnt   <= CNT_LOAD;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase

      // mem_rdata is sampled on the edge that enters RESP, for reads only
      if (enter_resp) begin
        bus.done0 <= ~owner;
        bus.done1 <= owner;
        if (!we_q) begin
          if (owner) bus.rdata1 <= bus.mem_rdata;
          else       bus.rdata0 <= bus.mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: latency 1 main instance plus latency 0 and 3 instances.
module tb_dmem_port_arbiter;

  localparam logic [63:0] BAD = 64'hBAD0_BAD0_BAD0_BAD0;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter_if #(.ADDR_W(64), .DATA_W(64)) b1 ();
  dmem_port_arbiter_if #(.ADDR_W(64), .DATA_W(64)) b0 ();
  dmem_port_arbiter_if #(.ADDR_W(64), .DATA_W(64)) b3 ();

  dmem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LATENCY(1)) u_l1 (.clk(clk), .reset(reset), .bus(b1));
  dmem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LATENCY(0)) u_l0 (.clk(clk), .reset(reset), .bus(b0));
  dmem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LATENCY(3)) u_l3 (.clk(clk), .reset(reset), .bus(b3));

  // memory model: 0x10 is preloaded, everything else comes from port-1 writes of the main instance
  logic [63:0] mem [0:255];
  logic        v1 = 1'b0;
  logic [2:0]  v3 = 3'b000;

  function automatic logic [63:0] mrd(input logic [7:0] a);
    return (a == 8'h10) ? 64'hDEAD_BEEF : mem[a];
  endfunction

  always @(posedge clk) begin
    if (b1.mem_write) mem[b1.mem_addr[7:0]] <= b1.mem_wdata;
    v1 <= b1.mem_read;
    v3 <= {v3[1:0], b3.mem_read};
  end

  assign b1.mem_rdata = v1       ? mrd(b1.mem_addr[7:0]) : BAD;
  assign b0.mem_rdata = b0.mem_read ? mrd(b0.mem_addr[7:0]) : BAD;
  assign b3.mem_rdata = v3[2]    ? mrd(b3.mem_addr[7:0]) : BAD;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k;
    int extra;
    logic [3:0] exp_rr;
`ifdef DMEM_FIXED_PRIO_EN
    exp_rr = 4'b0000;
`else
    exp_rr = 4'b1010;
`endif
    b1.req0 = 0; b1.req1 = 0; b1.we0 = 0; b1.we1 = 0;
    b1.addr0 = '0; b1.addr1 = '0; b1.wdata0 = '0; b1.wdata1 = '0;
    b0.req0 = 0; b0.req1 = 0; b0.we0 = 0; b0.we1 = 0;
    b0.addr0 = 64'h10; b0.addr1 = '0; b0.wdata0 = '0; b0.wdata1 = '0;
    b3.req0 = 0; b3.req1 = 0; b3.we0 = 0; b3.we1 = 0;
    b3.addr0 = 64'h10; b3.addr1 = '0; b3.wdata0 = '0; b3.wdata1 = '0;

    // reset state
    step(); step();
    chk("rst_gnt0", b1.gnt0, 0);
    chk("rst_gnt1", b1.gnt1, 0);
    chk("rst_done0", b1.done0, 0);
    chk("rst_mem_read", b1.mem_read, 0);
    chk("rst_mem_write", b1.mem_write, 0);
    chk("rst_mem_addr", b1.mem_addr, 0);
    chk("rst_rdata0", b1.rdata0, 0);
    chk("rst_rdata1", b1.rdata1, 0);
    reset = 1;
    step();

    // port 0 read of 0x10
    b1.req0 = 1; b1.we0 = 0; b1.addr0 = 64'h10;
    step();
    chk("a_gnt0", b1.gnt0, 1);
    chk("a_gnt1", b1.gnt1, 0);
    chk("a_mem_read", b1.mem_read, 1);
    chk("a_mem_write", b1.mem_write, 0);
    chk("a_mem_addr", b1.mem_addr, 64'h10);
    step();
    chk("a_gnt0_off", b1.gnt0, 0);
    chk("a_mem_read_off", b1.mem_read, 0);
    chk("a_done0_early", b1.done0, 0);
    step();
    chk("a_done0", b1.done0, 1);
    chk("a_done1", b1.done1, 0);
    chk("a_rdata0", b1.rdata0, 64'hDEAD_BEEF);
    chk("a_rdata1", b1.rdata1, 0);
    b1.req0 = 0;
    step();
    chk("a_done0_once", b1.done0, 0);

    // port 1 write 0x1234 to 0x20
    b1.req1 = 1; b1.we1 = 1; b1.addr1 = 64'h20; b1.wdata1 = 64'h1234;
    step();
    chk("b_gnt1", b1.gnt1, 1);
    chk("b_gnt0", b1.gnt0, 0);
    chk("b_mem_write", b1.mem_write, 1);
    chk("b_mem_read", b1.mem_read, 0);
    chk("b_mem_addr", b1.mem_addr, 64'h20);
    chk("b_mem_wdata", b1.mem_wdata, 64'h1234);
    step();
    chk("b_mem_write_off", b1.mem_write, 0);
    chk("b_mem_addr_hold", b1.mem_addr, 64'h20);
    step();
    chk("b_done1", b1.done1, 1);
    chk("b_done0", b1.done0, 0);
    chk("b_rdata1_write", b1.rdata1, 0);
    chk("b_rdata0_kept", b1.rdata0, 64'hDEAD_BEEF);
    b1.req1 = 0;
    step();

    // port 0 read of 0x20, req dropped right after gnt
    b1.req0 = 1; b1.we0 = 0; b1.addr0 = 64'h20;
    step();
    chk("c_gnt0", b1.gnt0, 1);
    step();
    b1.req0 = 0;
    step();
    chk("c_done0", b1.done0, 1);
    chk("c_rdata0", b1.rdata0, 64'h1234);
    extra = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (b1.gnt0 || b1.done0) extra++;
    end
    chk("c_no_regrant", 64'(extra), 0);

    // latency 0 and latency 3 instances, same start edge
    b0.req0 = 1;
    b3.req0 = 1;
    for (int c = 1; c <= 6; c++) begin
      step();
      chk($sformatf("l0_gnt0_c%0d", c), b0.gnt0, (c == 1) ? 1 : 0);
      chk($sformatf("l0_done0_c%0d", c), b0.done0, (c == 2) ? 1 : 0);
      chk($sformatf("l3_done0_c%0d", c), b3.done0, (c == 5) ? 1 : 0);
      chk($sformatf("l3_mem_read_c%0d", c), b3.mem_read, (c == 1) ? 1 : 0);
      if (c <= 2) chk($sformatf("l0_mem_addr_c%0d", c), b0.mem_addr, 64'h10);
      if (c <= 5) chk($sformatf("l3_mem_addr_c%0d", c), b3.mem_addr, 64'h10);
      if (c == 2) begin
        chk("l0_rdata0", b0.rdata0, 64'hDEAD_BEEF);
        b0.req0 = 0;
      end
      if (c == 5) begin
        chk("l3_rdata0", b3.rdata0, 64'hDEAD_BEEF);
        b3.req0 = 0;
      end
    end
    step();

    // reset during WAIT of a port-0 read
    b1.req0 = 1; b1.we0 = 0; b1.addr0 = 64'h10;
    step();
    chk("r_gnt0", b1.gnt0, 1);
    step();
    reset = 0;
    #1;
    chk("r_gnt0_low", b1.gnt0, 0);
    chk("r_done0_low", b1.done0, 0);
    chk("r_mem_read_low", b1.mem_read, 0);
    chk("r_mem_write_low", b1.mem_write, 0);
    chk("r_mem_addr_low", b1.mem_addr, 0);
    chk("r_mem_wdata_low", b1.mem_wdata, 0);
    chk("r_rdata0_low", b1.rdata0, 0);
    extra = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (b1.done0 || b1.gnt0 || b1.mem_read) extra++;
    end
    chk("r_quiet_in_reset", 64'(extra), 0);

    // release with both ports requesting: arbitration order over 4 grants
    b1.req0 = 1; b1.we0 = 0; b1.addr0 = 64'h10;
    b1.req1 = 1; b1.we1 = 0; b1.addr1 = 64'h20;
    reset = 1;
    for (int g = 0; g < 4; g++) begin
      k = 0;
      while (!(b1.gnt0 || b1.gnt1) && k < 10) begin
        step();
        k++;
      end
      chk($sformatf("rr_gap_%0d", g), 64'(k), (g == 0) ? 1 : 3);
      chk($sformatf("rr_owner_%0d", g), b1.gnt1, exp_rr[g]);
      step();
    end
    step();
    b1.req0 = 0;
    b1.req1 = 0;
    step();
    step();
`ifdef DMEM_FIXED_PRIO_EN
    chk("rr_rdata1", b1.rdata1, 0);
`else
    chk("rr_rdata1", b1.rdata1, 64'h1234);
`endif
    chk("rr_rdata0", b1.rdata0, 64'hDEAD_BEEF);
    chk("rr_idle_gnt", {b1.gnt0, b1.gnt1}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
